// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// definitions
// Shared types and constants for the timer tick interface.
//   timer_frequency_t     : timer constants; a timer with constant v elapses
//                           every v+1 system clock cycles.
//   TIMER_FREQUENCY_LIST  : every timer_frequency_t member in enum order.
//   period_meter_state_t  : period_meter state machine encoding.
//   SYSTEM_CLOCK_HZ       : system clock frequency.
//   abs_diff()            : wrap-free unsigned distance between two values.
// -----------------------------------------------------------------------------
package definitions;

   localparam int unsigned SYSTEM_CLOCK_HZ = 32'd50_000_000;

   typedef enum logic [31:0] {
      TIMER_FREQUENCY_1HZ   = 32'd49_999_999,
      TIMER_FREQUENCY_10HZ  = 32'd4_999_999,
      TIMER_FREQUENCY_100HZ = 32'd499_999,
      TIMER_FREQUENCY_1KHZ  = 32'd49_999,
      TIMER_FREQUENCY_10KHZ = 32'd4_999,
      TIMER_FREQUENCY_100KHZ = 32'd499,
      TIMER_FREQUENCY_1MHZ  = 32'd49
   } timer_frequency_t;

   localparam int NUM_TIMER_FREQUENCIES = 7;

   // Enum members in declaration order; first match wins during classification.
   localparam timer_frequency_t TIMER_FREQUENCY_LIST [NUM_TIMER_FREQUENCIES] = '{
      TIMER_FREQUENCY_1HZ,
      TIMER_FREQUENCY_10HZ,
      TIMER_FREQUENCY_100HZ,
      TIMER_FREQUENCY_1KHZ,
      TIMER_FREQUENCY_10KHZ,
      TIMER_FREQUENCY_100KHZ,
      TIMER_FREQUENCY_1MHZ
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } period_meter_state_t;

   // Larger operand minus smaller, so the result never wraps.
   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] result;
      if (a >= b) begin
         result = a - b;
      end else begin
         result = b - a;
      end
      return result;
   endfunction

endpackage

// File: rtl/period_meter_edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
// Two-flop synchronizer followed by a previous-value register. rise is high
// for one cycle after the synchronized input goes from 0 to 1.
//   clock      in  : system clock
//   reset_s2_n in  : asynchronous active-low reset
//   async_in   in  : asynchronous input
//   rise       out : one-cycle rising-edge pulse (decoded from registers only)
// -----------------------------------------------------------------------------
module edge_detector (
   input  logic clock,
   input  logic reset_s2_n,
   input  logic async_in,
   output logic rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Synchronizer chain and previous-value register.
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= async_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Decoded purely from flops, so the pulse is glitch-free and one cycle wide.
   assign rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the number of system clock cycles between consecutive rising edges
// of pulse_in and classifies the result against timer_frequency_t.
//   TIMEOUT_CYCLES  : counter limit; measurement abandoned when reached
//   TOL_SHIFT       : tolerance is +/- (nominal >> TOL_SHIFT)
//   clock      in   : system clock
//   reset_s2_n in   : asynchronous active-low reset
//   enabled    in   : 1 = measuring, 0 = idle
//   pulse_in   in   : asynchronous pulse train
//   period     out  : cycles between the last two detected rising edges
//   valid      out  : one-cycle strobe when period/match/frequency update
//   match      out  : period within tolerance of a timer_frequency_t member
//   frequency  out  : matched member, held when match = 0
//   timeout    out  : no edge arrived within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module period_meter
   import definitions::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd550_000_000,
   parameter int unsigned TOL_SHIFT      = 32'd4
) (
   input  logic             clock,
   input  logic             reset_s2_n,
   input  logic             enabled,
   input  logic             pulse_in,
   output logic [31:0]      period,
   output logic             valid,
   output logic             match,
   output timer_frequency_t frequency,
   output logic             timeout
);

   logic                w_edge;
   logic                w_hit;
   timer_frequency_t    w_freq;
   logic [31:0]         w_nominal;

   period_meter_state_t r_state;
   logic [31:0]         r_count;
   logic [31:0]         r_period;
   logic                r_valid;
   logic                r_match;
   timer_frequency_t    r_frequency;
   logic                r_timeout;

   edge_detector u_edge_detector (
      .clock      (clock),
      .reset_s2_n (reset_s2_n),
      .async_in   (pulse_in),
      .rise       (w_edge)
   );

   // Classify the running count; the result is only captured on an edge in
   // MEASURE, where r_count is exactly the period being reported.
   always_comb begin
      w_hit     = 1'b0;
      w_freq    = TIMER_FREQUENCY_1HZ;
      w_nominal = 32'd0;
      for (int i = 0; i < NUM_TIMER_FREQUENCIES; i++) begin
         w_nominal = TIMER_FREQUENCY_LIST[i] + 32'd1;
         if (!w_hit && (abs_diff(r_count, w_nominal) <= (w_nominal >> TOL_SHIFT))) begin
            w_hit  = 1'b1;
            w_freq = TIMER_FREQUENCY_LIST[i];
         end else begin
            w_hit  = w_hit;
         end
      end
   end

   // Measurement state machine with registered outputs.
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         r_state     <= IDLE;
         r_count     <= 32'd0;
         r_period    <= 32'd0;
         r_valid     <= 1'b0;
         r_match     <= 1'b0;
         r_frequency <= TIMER_FREQUENCY_1HZ;
         r_timeout   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!enabled) begin
            // Disable wins over edges and timeouts in every state.
            r_state   <= IDLE;
            r_count   <= 32'd0;
            r_timeout <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_count <= 32'd0;
                  r_state <= ARM;
               end
               ARM: begin
                  if (w_edge) begin
                     r_count <= 32'd1;
                     r_state <= MEASURE;
                  end else begin
                     r_count <= 32'd0;
                  end
               end
               MEASURE: begin
                  // Edge is checked before the limit so an edge exactly at
                  // the limit still reports a period.
                  if (w_edge) begin
                     r_period  <= r_count;
                     r_valid   <= 1'b1;
                     r_timeout <= 1'b0;
                     r_match   <= w_hit;
                     r_count   <= 32'd1;
                     if (w_hit) begin
                        r_frequency <= w_freq;
                     end
                  end else if (r_count == TIMEOUT_CYCLES) begin
                     r_timeout <= 1'b1;
                     r_count   <= 32'd0;
                     r_state   <= ARM;
                  end else begin
                     r_count <= r_count + 32'd1;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_count <= 32'd0;
               end
            endcase
         end
      end
   end

   assign period    = r_period;
   assign valid     = r_valid;
   assign match     = r_match;
   assign frequency = r_frequency;
   assign timeout   = r_timeout;

endmodule
